// File: rtl/isram_load_ctrl.sv
// Boot-time loader for the instruction SRAM: holds the CPU in reset, streams words into
// the four byte lanes, then hands the SRAM port to the CPU. Optional tail clear: ISRAM_LOAD_CLEAR_EN.
module isram_load_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              hclk,
  input  logic              hrst_b,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_vld,
  input  logic [31:0]       ld_data,
  output logic              ld_rdy,
  output logic              ld_done,
  output logic              ld_err,
  output logic              core_hold,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic [31:0]       cpu_rdata,
  output logic              ram_cen,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
`ifdef ISRAM_LOAD_CLEAR_EN
    S_CLEAR = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = DEPTH_L - 1'b1;

  // Where the sequence goes once the loaded words run out before the end of the SRAM.
`ifdef ISRAM_LOAD_CLEAR_EN
  localparam state_e TAIL_STATE = S_CLEAR;
`else
  localparam state_e TAIL_STATE = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [ADDR_W:0] len_clamped;
  logic [31:0]     ld_data_lanes;

  assign len_clamped   = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
  assign ld_data_lanes = {ld_data[7:0], ld_data[15:8], ld_data[23:16], ld_data[31:24]};
  assign ld_err        = err_q;
  assign cpu_rdata     = ram_dout;

  always_comb begin
    // NOTE: every output and next-state value gets a default here so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    core_hold = 1'b1;
    ld_rdy    = 1'b0;
    ld_done   = 1'b0;
    cpu_gnt   = 1'b0;
    ram_cen   = 1'b1;
    ram_wen   = 4'hF;
    ram_addr  = '0;
    ram_din   = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ld_start) begin
          cnt_d   = len_clamped;
          ptr_d   = '0;
          err_d   = (ld_len > DEPTH_L);
          state_d = (ld_len == '0) ? TAIL_STATE : S_LOAD;
        end else if (state_q == S_DONE) begin
          core_hold = 1'b0;
          ld_done   = 1'b1;
          cpu_gnt   = 1'b1;
          ram_cen   = ~cpu_req;
          ram_wen   = ~cpu_wen;
          ram_addr  = cpu_addr;
          ram_din   = cpu_wdata;
        end
      end

      S_LOAD: begin
        ld_rdy   = 1'b1;
        ram_addr = ptr_q[ADDR_W-1:0];
        ram_din  = ld_data_lanes;
        if (ld_vld) begin
          ram_cen = 1'b0;
          ram_wen = 4'h0;
          ptr_d   = ptr_q + 1'b1;
          if (ptr_q == cnt_q - 1'b1) begin
            state_d = (cnt_q == DEPTH_L) ? S_DONE : TAIL_STATE;
          end
        end
      end

`ifdef ISRAM_LOAD_CLEAR_EN
      S_CLEAR: begin
        ram_cen  = 1'b0;
        ram_wen  = 4'h0;
        ram_addr = ptr_q[ADDR_W-1:0];
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == LAST_L) begin
          state_d = S_DONE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: only the control flops are reset; the SRAM array itself keeps whatever was
  // written, so a mid-load reset leaves partial contents behind by design.
  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
